// File: rtl/cpu_cluster_pkg.sv
// Constants shared across the CPU cluster: instruction word width and default core count.
// No logic, so no latency and no backpressure.
package cpu_cluster_pkg;

    localparam int INSTR_W       = 32;
    localparam int DEFAULT_NCPUS = 3;

endpackage : cpu_cluster_pkg

// File: rtl/round_robin_arbiter.sv
// Round-robin grant among nCPUs requesters. The grant is combinational in the request cycle.
// A held request is served within nCPUs cycles. Grants are suppressed while rst is high.
module round_robin_arbiter
    import cpu_cluster_pkg::*;
#(
    parameter int nCPUs = DEFAULT_NCPUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [nCPUs-1:0] req,
    output logic [nCPUs-1:0] gnt
);

    localparam int PW = $clog2(nCPUs);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptrNext;
    logic [PW-1:0] winner;
    logic          found;
    int            idx;

    // Walk from ptr upward with wrap; the first requester hit wins.
    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < nCPUs; k++) begin
            idx = int'(ptr) + k;
            if (idx >= nCPUs) begin
                idx = idx - nCPUs;
            end
            if (!rst && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = PW'(idx);
            end
        end
    end

    always_comb begin
        ptrNext = ptr;
        if (found) begin
            ptrNext = (winner == PW'(nCPUs - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptrNext;
        end
    end

endmodule : round_robin_arbiter

// File: rtl/instr_mem_arbiter.sv
// Shares one synchronous-read instruction memory among nCPUs cores. There is one grant per cycle, and the response comes 1 cycle later.
// There is no stall path. A core waits with req held, and it is served within nCPUs cycles.
module instr_mem_arbiter
    import cpu_cluster_pkg::*;
#(
    parameter int nCPUs = DEFAULT_NCPUS,
    parameter int aw    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [nCPUs-1:0]        req,
    input  logic [nCPUs-1:0][31:0]  reqAddr,
    output logic [nCPUs-1:0]        gnt,
    output logic [nCPUs-1:0]        rspValid,
    output logic [INSTR_W-1:0]      rspInstr,
    output logic                    memRead,
    output logic [aw-1:0]           memAddr,
    input  logic [INSTR_W-1:0]      memRdata
);

    logic [nCPUs-1:0] rspSel;

    round_robin_arbiter #(
        .nCPUs (nCPUs)
    ) uArb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign memRead = |gnt;

    // gnt is one-hot or zero, so an AND-OR mux yields 0 when idle.
    always_comb begin
        memAddr = '0;
        for (int i = 0; i < nCPUs; i++) begin
            if (gnt[i]) begin
                memAddr = memAddr | reqAddr[i][aw+1:2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rspSel <= '0;
        end else begin
            rspSel <= gnt;
        end
    end

    assign rspValid = rspSel;
    assign rspInstr = (|rspSel) ? memRdata : '0;

endmodule : instr_mem_arbiter
